word_bit_serializer: RTL and testbench

Parallel-to-serial front end for the bit-stream pattern-detection path. Accepts WIDTH-bit words over a valid/ready handshake. Emits them one bit per clock as a bit/valid pair that connects directly to dynamic_pattern_detector's d_in/valid_in. A one-word pending buffer lets back-to-back words stream with no gap between bits.

---
 rtl/serializer_pkg.sv | 20 ++
 rtl/word_pending_buffer.sv | 48 ++++
 rtl/word_bit_serializer.sv | 151 +++++++++++++++
 tb/tb_word_bit_serializer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// rtl/serializer_pkg.sv - shared state encoding and defaults for word_bit_serializer
// Optional feature macro: SERIALIZER_PARITY_EN (adds the PARITY state).
package serializer_pkg;

    localparam int DEFAULT_WIDTH = 8;

`ifdef SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } ser_state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } ser_state_e;
`endif

endpackage

// File: rtl/word_pending_buffer.sv
// rtl/word_pending_buffer.sv - single-entry holding register with full flag
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   load_i, data_i  - capture data_i and set full
//   unload_i        - release the entry (clears full); load wins if both set
//   data_o, full_o  - held word and occupancy flag
module word_pending_buffer
    import serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             unload_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             full_q, full_d;

    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (load_i) begin
            data_d = data_i;
            full_d = 1'b1;
        end else if (unload_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule

// File: rtl/word_bit_serializer.sv
// rtl/word_bit_serializer.sv - parallel word to one-bit-per-clock serializer with pending buffer
// Optional feature macro: SERIALIZER_PARITY_EN (even-parity bit appended after each word).
// Ports:
//   clk, reset             - clock, asynchronous active-high reset
//   word_in, word_valid    - producer word and valid
//   word_ready             - registered ready flag (no path from word_valid)
//   bit_out, bit_valid     - serial stream to the pattern detector
//   frame_done             - pulse with the final bit of each word
//   busy                   - shifter active or pending word held
module word_bit_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             ready_q, ready_d;
`ifdef SERIALIZER_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             accept;
    logic             last_data;
    logic             word_end;
    logic             pend_load, pend_unload, pend_full, pend_full_next;
    logic [WIDTH-1:0] pend_data;
    logic             load_shifter;
    logic [WIDTH-1:0] load_word;

    assign accept    = word_valid && ready_q;
    assign last_data = (state_q == ST_SHIFT) && (bit_cnt_q == CW'(WIDTH - 1));
`ifdef SERIALIZER_PARITY_EN
    assign word_end  = (state_q == ST_PARITY);
`else
    assign word_end  = last_data;
`endif

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        pend_load    = 1'b0;
        pend_unload  = 1'b0;
        load_shifter = 1'b0;
        load_word    = word_in;
`ifdef SERIALIZER_PARITY_EN
        par_d        = par_q;
`endif
        // Idle or the final cycle of a word is where the shifter can take a new
        // word; the pending word has priority since it was accepted earlier.
        if (state_q == ST_IDLE || word_end) begin
            if (pend_full) begin
                load_shifter = 1'b1;
                load_word    = pend_data;
                pend_unload  = 1'b1;
            end else if (accept) begin
                load_shifter = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            pend_load = accept;
            if (state_q == ST_SHIFT) begin
                shift_d   = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                                      : {1'b0, shift_q[WIDTH-1:1]};
                bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef SERIALIZER_PARITY_EN
                if (last_data) begin
                    state_d = ST_PARITY;
                end
`endif
            end
        end

        if (load_shifter) begin
            state_d   = ST_SHIFT;
            shift_d   = load_word;
            bit_cnt_d = '0;
`ifdef SERIALIZER_PARITY_EN
            par_d     = ^load_word;
`endif
        end
    end

    // Ready mirrors the pending flag one edge ahead, so it is a pure register.
    assign pend_full_next = pend_load ? 1'b1 : (pend_unload ? 1'b0 : pend_full);
    assign ready_d        = !pend_full_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            ready_q   <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            ready_q   <= ready_d;
`ifdef SERIALIZER_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    word_pending_buffer #(.WIDTH(WIDTH)) u_pending (
        .clk      (clk),
        .reset    (reset),
        .load_i   (pend_load),
        .unload_i (pend_unload),
        .data_i   (word_in),
        .data_o   (pend_data),
        .full_o   (pend_full)
    );

    always_comb begin
        bit_out = 1'b0;
        if (state_q == ST_SHIFT) begin
            bit_out = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
        end
`ifdef SERIALIZER_PARITY_EN
        else if (state_q == ST_PARITY) begin
            bit_out = par_q;
        end
`endif
    end

    assign bit_valid  = (state_q != ST_IDLE);
    assign frame_done = word_end;
    assign busy       = (state_q != ST_IDLE) || pend_full;
    assign word_ready = ready_q;

endmodule

// File: tb/tb_word_bit_serializer.sv
// tb/tb_word_bit_serializer.sv - self-checking bench for word_bit_serializer (MSB- and LSB-first instances)
module tb_word_bit_serializer;

    localparam int W = 8;
`ifdef SERIALIZER_PARITY_EN
    localparam int L = W + 1;
`else
    localparam int L = W;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] word_in = '0;
    logic         word_valid = 1'b0;

    logic a_rdy, a_bit, a_valid, a_fd, a_busy;
    logic b_rdy, b_bit, b_valid, b_fd, b_busy;

    word_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .word_in(word_in), .word_valid(word_valid),
        .word_ready(a_rdy), .bit_out(a_bit), .bit_valid(a_valid),
        .frame_done(a_fd), .busy(a_busy)
    );

    word_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .word_in(word_in), .word_valid(word_valid),
        .word_ready(b_rdy), .bit_out(b_bit), .bit_valid(b_valid),
        .frame_done(b_fd), .busy(b_busy)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of the serial cycles still owed to the consumer.
    typedef struct { bit m; bit l; bit last; } ent_t;
    ent_t q[$];
    ent_t e;
    bit   rdy_m = 1'b0;
    bit   acc_now;
    int   acc_cnt = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            rdy_m = 1'b0;
        end else begin
            acc_now = word_valid && rdy_m;
            if (q.size() > 0) q.delete(0);
            if (acc_now) begin
                for (int i = 0; i < W; i++) begin
                    e.m = word_in[W-1-i];
                    e.l = word_in[i];
                    e.last = (i == W - 1) && (L == W);
                    q.push_back(e);
                end
                if (L > W) begin
                    e.m = ^word_in; e.l = ^word_in; e.last = 1'b1;
                    q.push_back(e);
                end
                acc_cnt++;
            end
            // A second word is waiting exactly when more than one word remains.
            rdy_m = (q.size() <= L);
        end
    end

    wire [9:0] obs = {a_valid, a_bit, a_fd, a_busy, a_rdy, b_valid, b_bit, b_fd, b_busy, b_rdy};

    function automatic logic [9:0] exp_vec();
        logic v;
        logic m, l, f;
        v = (q.size() > 0);
        m = v ? q[0].m : 1'b0;
        l = v ? q[0].l : 1'b0;
        f = v ? q[0].last : 1'b0;
        return {v, m, f, v, rdy_m, v, l, f, v, rdy_m};
    endfunction

    // Stream monitor: longest valid run and frame_done timestamps.
    bit mon_en = 1'b0;
    int cyc = 0, run_len = 0, max_run = 0;
    int fd_times[$];
    always @(negedge clk) begin
        cyc++;
        if (!mon_en) begin
            run_len = 0; max_run = 0; fd_times.delete();
        end else begin
            run_len = a_valid ? run_len + 1 : 0;
            if (run_len > max_run) max_run = run_len;
            if (a_fd) fd_times.push_back(cyc);
        end
    end

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (obs !== 10'b0) begin
            n_fail++; $display("FAIL reset_state got=%b want=%b", obs, 10'b0);
        end
        #2 reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (obs !== exp_vec() || a_rdy !== 1'b1) begin
            n_fail++; $display("FAIL reset_release got=%b want=%b", obs, exp_vec());
        end
    endtask

    task automatic test_single(input logic [W-1:0] w, input string name);
        int start, nb;
        logic [W-1:0] msb_w, lsb_w;
        logic par;
        start = acc_cnt; nb = 0; msb_w = '0; lsb_w = '0; par = 1'b0;
        word_in = w; word_valid = 1'b1;
        for (int c = 0; c < 40 && acc_cnt == start; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL %s_wait got=%b want=%b", name, obs, exp_vec());
            end
        end
        word_valid = 1'b0;
        n_checks++;
        if (acc_cnt == start) begin
            n_fail++; $display("FAIL %s_accept_timeout got=0 want=1", name);
        end
        for (int c = 0; c < L + 2; c++) begin
            if (a_valid) begin
                if (nb < W) begin
                    msb_w = {msb_w[W-2:0], a_bit};
                    lsb_w[nb] = b_bit;
                end else begin
                    par = a_bit;
                end
                nb++;
            end
            @(posedge clk); #1;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL %s_cycle%0d got=%b want=%b", name, c, obs, exp_vec());
            end
        end
        n_checks++;
        if (nb !== L || msb_w !== w || lsb_w !== w) begin
            n_fail++;
            $display("FAIL %s_bits got n=%0d msb=%h lsb=%h want n=%0d word=%h", name, nb, msb_w, lsb_w, L, w);
        end
`ifdef SERIALIZER_PARITY_EN
        n_checks++;
        if (par !== ^w) begin
            n_fail++; $display("FAIL %s_parity got=%b want=%b", name, par, ^w);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [3];
        int start;
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
        mon_en = 1'b1;
        word_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start = acc_cnt;
            word_in = words[k];
            for (int c = 0; c < 40 && acc_cnt == start; c++) begin
                @(posedge clk); #1;
                n_checks++;
                if (obs !== exp_vec()) begin
                    n_fail++; $display("FAIL b2b_word%0d got=%b want=%b", k, obs, exp_vec());
                end
            end
            n_checks++;
            if (acc_cnt == start) begin
                n_fail++; $display("FAIL b2b_accept_timeout%0d got=0 want=1", k);
            end
        end
        word_valid = 1'b0;
        for (int c = 0; c < 3 * L + 2; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL b2b_drain%0d got=%b want=%b", c, obs, exp_vec());
            end
        end
        @(negedge clk); #1;
        n_checks++;
        if (max_run !== 3 * L || fd_times.size() !== 3) begin
            n_fail++; $display("FAIL b2b_gapless got run=%0d fd=%0d want run=%0d fd=3", max_run, fd_times.size(), 3 * L);
        end else begin
            n_checks++;
            if (fd_times[1] - fd_times[0] !== L || fd_times[2] - fd_times[1] !== L) begin
                n_fail++; $display("FAIL b2b_fd_spacing got=%0d,%0d want=%0d", fd_times[1] - fd_times[0], fd_times[2] - fd_times[1], L);
            end
        end
        mon_en = 1'b0;
    endtask

    task automatic test_async_reset();
        int start;
        start = acc_cnt;
        word_in = 8'hA5; word_valid = 1'b1;
        @(posedge clk); #1;
        word_in = 8'h3C;
        @(posedge clk); #1;
        word_valid = 1'b0;
        n_checks++;
        if (acc_cnt - start !== 2 || obs !== exp_vec() || a_busy !== 1'b1 || a_rdy !== 1'b0) begin
            n_fail++; $display("FAIL arst_setup got acc=%0d obs=%b want acc=2 obs=%b", acc_cnt - start, obs, exp_vec());
        end
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if (obs !== 10'b0) begin
            n_fail++; $display("FAIL arst_immediate got=%b want=%b", obs, 10'b0);
        end
        @(posedge clk); #3;
        reset = 1'b0;
        for (int c = 0; c < L + 4; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (obs !== exp_vec() || a_valid !== 1'b0 || a_rdy !== 1'b1) begin
                n_fail++; $display("FAIL arst_after%0d got=%b want=%b", c, obs, exp_vec());
            end
        end
    endtask

    task automatic test_idle_gap();
        int vcount;
        test_single(8'h5A, "gap_first");
        vcount = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (a_valid || b_valid) vcount++;
        end
        n_checks++;
        if (vcount !== 0) begin
            n_fail++; $display("FAIL gap_idle got=%0d want=0", vcount);
        end
        test_single(8'hC3, "gap_second");
    endtask

    task automatic test_random();
        int prev;
        prev = acc_cnt;
        for (int c = 0; c < 400; c++) begin
            if (acc_cnt != prev) word_valid = 1'b0;
            prev = acc_cnt;
            if (!word_valid && $urandom_range(3) != 0) begin
                word_valid = 1'b1;
                word_in = W'($urandom);
            end
            @(posedge clk); #1;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL random_cycle%0d got=%b want=%b", c, obs, exp_vec());
            end
        end
        word_valid = 1'b0;
        for (int c = 0; c < 2 * L + 2; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL random_drain%0d got=%b want=%b", c, obs, exp_vec());
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single(8'hA5, "single_a5");
        test_single(8'h01, "single_01");
        test_single(8'h07, "single_07");
        test_back_to_back();
        test_async_reset();
        test_idle_gap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
